// File: rtl/fetch_stage.sv
// fetch_stage
// PC generation and IF/ID pipeline register for the 5-stage core.
// The block issues one instruction-memory request at a time over a
// req/gnt/rvalid handshake. It holds at most one fetched word in a skid
// buffer while decode is stalled. It redirects to the execute-stage branch
// target and drops stale in-flight responses.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   StallF                 blocks issue of new imem requests
//   StallD                 IF/ID holds its contents
//   FlushD                 IF/ID loads a bubble (wins over StallD)
//   br_taken, br_target    execute-stage redirect and its target address
//   imem_req, imem_addr    request valid / address (combinational from state, pcF, StallF)
//   imem_gnt               request accepted this cycle
//   imem_rvalid, imem_rdata  in-order response, one per grant
//   instrD, pcD, pc4D, validD  IF/ID register contents
`timescale 1ns/1ps
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic [31:0] pc4D,
    output logic        validD
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] pcF, pc_next;
    logic [31:0] pc_pend, pc_pend_next;
    logic        kill, kill_next;
    logic [31:0] buf_instr, buf_pc;
    logic        buf_load;
    logic        deliver;
    logic [31:0] deliver_instr, deliver_pc;

    assign imem_addr = pcF;

    always_comb begin
        state_next    = state;
        pc_next       = pcF;
        pc_pend_next  = pc_pend;
        kill_next     = kill;
        buf_load      = 1'b0;
        deliver       = 1'b0;
        deliver_instr = buf_instr;
        deliver_pc    = buf_pc;
        imem_req      = 1'b0;

        case (state)
            S_REQ: begin
                imem_req = !StallF;
                if (!StallF && imem_gnt) begin
                    pc_pend_next = pcF;
                    pc_next      = pcF + 32'd4;
                    // A redirect in the grant cycle makes this request stale at once.
                    kill_next    = br_taken;
                    state_next   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (kill || br_taken) begin
                        kill_next  = 1'b0;
                        state_next = S_REQ;
                    end else if (!StallD) begin
                        deliver       = 1'b1;
                        deliver_instr = imem_rdata;
                        deliver_pc    = pc_pend;
                        state_next    = S_REQ;
                    end else begin
                        buf_load   = 1'b1;
                        state_next = S_FULL;
                    end
                end else if (br_taken) begin
                    kill_next = 1'b1;
                end
            end
            S_FULL: begin
                // A redirect drops the buffered word even if decode is free.
                if (br_taken) begin
                    state_next = S_REQ;
                end else if (!StallD) begin
                    deliver    = 1'b1;
                    state_next = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase

        // The redirect target overrides any +4 from a same-cycle grant.
        if (br_taken) begin
            pc_next = br_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_REQ;
            pcF     <= RESET_PC;
            pc_pend <= 32'd0;
            kill    <= 1'b0;
        end else begin
            state   <= state_next;
            pcF     <= pc_next;
            pc_pend <= pc_pend_next;
            kill    <= kill_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_instr <= 32'd0;
            buf_pc    <= 32'd0;
        end else if (buf_load) begin
            buf_instr <= imem_rdata;
            buf_pc    <= pc_pend;
        end
    end

    // IF/ID register: flush, then stall, then delivery, else bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instrD <= NOP;
            pcD    <= 32'd0;
            pc4D   <= 32'd0;
            validD <= 1'b0;
        end else if (FlushD) begin
            instrD <= NOP;
            validD <= 1'b0;
        end else if (!StallD) begin
            if (deliver) begin
                instrD <= deliver_instr;
                pcD    <= deliver_pc;
                pc4D   <= deliver_pc + 32'd4;
                validD <= 1'b1;
            end else begin
                instrD <= NOP;
                validD <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        StallF, StallD, FlushD, br_taken;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instrD, pcD, pc4D;
    logic        validD;

    fetch_stage #(.RESET_PC(RST_PC), .NOP(NOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .br_taken(br_taken), .br_target(br_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instrD(instrD), .pcD(pcD), .pc4D(pc4D), .validD(validD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory model: one outstanding response, delivered lat+1 cycles after grant.
    logic        resp_pend;
    logic [31:0] resp_addr;
    int          resp_cnt;

    // Reference model: what is in flight, what is buffered, what decode sees.
    logic [31:0] m_pcF;
    logic        m_out, m_out_stale;
    logic [31:0] m_out_pc;
    logic        m_buf;
    logic [31:0] m_buf_pc, m_buf_instr;
    logic [31:0] e_instr, e_pc, e_pc4;
    logic        e_valid;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0010_0093;
        if (a == 32'h4) return 32'h0020_0113;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_pcF = RST_PC; m_out = 1'b0; m_out_stale = 1'b0; m_out_pc = 32'd0;
        m_buf = 1'b0; m_buf_pc = 32'd0; m_buf_instr = 32'd0;
        e_instr = NOP; e_pc = 32'd0; e_pc4 = 32'd0; e_valid = 1'b0;
        resp_pend = 1'b0; resp_addr = 32'd0; resp_cnt = 0;
    endtask

    task automatic check_reset_values(input string tag);
        chk32({tag, "_instrD"}, instrD, NOP);
        chk32({tag, "_pcD"}, pcD, 32'd0);
        chk32({tag, "_pc4D"}, pc4D, 32'd0);
        chk1({tag, "_validD"}, validD, 1'b0);
        chk32({tag, "_addr"}, imem_addr, RST_PC);
        chk1({tag, "_req"}, imem_req, 1'b1);
    endtask

    // One clock cycle: called just after a falling edge, returns at the next one.
    task automatic step(input logic sf, input logic sd, input logic fd, input logic br,
                        input logic [31:0] tgt, input logic g, input int lat);
        logic        exp_req, rv, dlv;
        logic [31:0] rd, dpc, dins;
        StallF = sf; StallD = sd; FlushD = fd; br_taken = br; br_target = tgt; imem_gnt = g;
        rv = resp_pend && (resp_cnt == 0);
        rd = rv ? mem_word(resp_addr) : $urandom;
        imem_rvalid = rv;
        imem_rdata  = rd;
        #1;
        exp_req = !m_out && !m_buf && !sf;
        chk1("imem_req", imem_req, exp_req);
        chk32("imem_addr", imem_addr, m_pcF);

        if (rv) resp_pend = 1'b0;
        else if (resp_pend) resp_cnt--;
        if (exp_req && g) begin
            resp_pend = 1'b1; resp_addr = m_pcF; resp_cnt = lat;
        end

        dlv = 1'b0; dpc = 32'd0; dins = 32'd0;
        if (m_out) begin
            if (rv) begin
                m_out = 1'b0;
                if (!m_out_stale && !br) begin
                    if (!sd) begin
                        dlv = 1'b1; dpc = m_out_pc; dins = rd;
                    end else begin
                        m_buf = 1'b1; m_buf_pc = m_out_pc; m_buf_instr = rd;
                    end
                end
                m_out_stale = 1'b0;
            end else if (br) begin
                m_out_stale = 1'b1;
            end
        end else if (m_buf) begin
            if (br) m_buf = 1'b0;
            else if (!sd) begin
                dlv = 1'b1; dpc = m_buf_pc; dins = m_buf_instr; m_buf = 1'b0;
            end
        end else if (exp_req && g) begin
            m_out = 1'b1; m_out_pc = m_pcF; m_out_stale = br; m_pcF = m_pcF + 32'd4;
        end
        if (br) m_pcF = tgt;

        if (fd) begin
            e_instr = NOP; e_valid = 1'b0;
        end else if (!sd) begin
            if (dlv) begin
                e_instr = dins; e_pc = dpc; e_pc4 = dpc + 32'd4; e_valid = 1'b1;
            end else begin
                e_instr = NOP; e_valid = 1'b0;
            end
        end

        @(posedge clk);
        @(negedge clk);
        chk32("instrD", instrD, e_instr);
        chk32("pcD", pcD, e_pc);
        chk32("pc4D", pc4D, e_pc4);
        chk1("validD", validD, e_valid);
        if (validD === 1'b1) chk32("instr_vs_mem", instrD, mem_word(pcD));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; br_taken = 1'b0;
        br_target = 32'd0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        reset_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset_values("reset");

        // Straight-line fetch across the address wrap.
        step(0, 0, 0, 0, 32'd0, 1, 0);          // grant at FFFFFFFC
        step(0, 0, 0, 0, 32'd0, 0, 0);          // deliver FFFFFFFC
        chk32("wrap_pc4D", pc4D, 32'h0);
        chk32("wrap_next_addr", imem_addr, 32'h0);
        step(0, 0, 0, 0, 32'd0, 1, 0);          // grant at 0
        step(0, 0, 0, 0, 32'd0, 0, 0);          // deliver 0
        chk32("line_pcD0", pcD, 32'h0);
        chk32("line_instr0", instrD, 32'h0010_0093);
        step(0, 0, 0, 0, 32'd0, 1, 0);          // grant at 4
        step(0, 0, 0, 0, 32'd0, 0, 0);          // deliver 4
        chk32("line_pcD4", pcD, 32'h4);
        chk32("line_pc4D8", pc4D, 32'h8);
        chk1("line_valid", validD, 1'b1);

        // Decode stall while the response arrives: word goes to the buffer.
        step(0, 0, 0, 0, 32'd0, 1, 0);          // grant at 8
        step(0, 1, 0, 0, 32'd0, 1, 0);          // rvalid under stall
        step(0, 1, 0, 0, 32'd0, 1, 0);
        chk1("stall_no_req", imem_req, 1'b0);
        step(0, 1, 0, 0, 32'd0, 1, 0);
        chk32("stall_hold_pcD", pcD, 32'h4);
        step(0, 0, 0, 0, 32'd0, 0, 0);          // stall released
        chk32("buf_pcD", pcD, 32'h8);
        chk32("buf_instr", instrD, mem_word(32'h8));

        // Redirect with a request outstanding.
        step(0, 0, 0, 0, 32'd0, 1, 2);          // grant at C, slow response
        step(0, 0, 1, 1, 32'h100, 0, 0);        // redirect + flush before rvalid
        chk1("redir_flush_valid", validD, 1'b0);
        step(0, 0, 0, 0, 32'd0, 0, 0);
        step(0, 0, 0, 0, 32'd0, 0, 0);          // stale C response dropped
        chk32("redir_addr", imem_addr, 32'h100);
        chk1("redir_req", imem_req, 1'b1);
        step(0, 0, 0, 0, 32'd0, 1, 0);          // grant at 100
        step(0, 0, 0, 0, 32'd0, 0, 0);
        chk32("redir_pcD", pcD, 32'h100);

        // Redirect in the grant cycle.
        step(1, 0, 0, 1, 32'h10, 0, 0);         // move pcF to 0x10
        step(0, 0, 0, 1, 32'h200, 1, 0);        // grant at 0x10 with redirect
        chk32("gnt_redir_addr", imem_addr, 32'h200);
        step(0, 0, 0, 0, 32'd0, 0, 0);          // 0x10 response discarded
        chk1("gnt_redir_drop", validD, 1'b0);
        step(0, 0, 0, 0, 32'd0, 1, 0);          // grant at 0x200
        step(0, 0, 0, 0, 32'd0, 0, 0);
        chk32("gnt_redir_pcD", pcD, 32'h200);

        // Flush and stall together: flush wins.
        step(0, 1, 1, 0, 32'd0, 0, 0);
        chk32("flush_stall_instr", instrD, 32'h0000_0013);
        chk1("flush_stall_valid", validD, 1'b0);

        // Asynchronous reset in the middle of a WAIT.
        step(0, 0, 0, 0, 32'd0, 1, 3);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset_values("release");

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                 tgt, $urandom_range(0, 9) < 6, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

PC generation and IF/ID pipeline register for the 5-stage core. Issues one instruction-memory request at a time over a req/gnt/rvalid handshake and holds at most one fetched word in a skid buffer while decode is stalled. Redirects to the branch target from execute and drops stale in-flight responses. Consumes `StallF`/`StallD`/`FlushD` from the hazard unit and feeds `instrD`/`pcD` to decode.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `NOP`, default `32'h0000_0013`: `addi x0,x0,0`, the bubble encoding.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `StallF` in 1: blocks issue of new imem requests.
- `StallD` in 1: IF/ID holds its contents.
- `FlushD` in 1: IF/ID loads a bubble.
- `br_taken` in 1: execute-stage redirect.
- `br_target` in 32: redirect address, valid with `br_taken`.
- `imem_req` out 1: request valid.
- `imem_addr` out 32: request address, equal to `pcF`.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: response valid; exactly one per grant, in order, 1 or more cycles after the grant.
- `imem_rdata` in 32: response instruction.
- `instrD` out 32: IF/ID instruction.
- `pcD` out 32: IF/ID PC.
- `pc4D` out 32: IF/ID PC+4.
- `validD` out 1: IF/ID holds a real instruction.

## Operation
Internal registers:
- `pcF`: next fetch address.
- `pc_pend`: address of the outstanding request.
- `kill`: outstanding response is stale.
- `buf_instr`, `buf_pc`: skid buffer.
- `state`: REQ, WAIT or FULL.

FSM:
- **REQ**
  - `imem_req = !StallF`.
  - On `imem_req & imem_gnt`: `pc_pend <= pcF`, `pcF <= pcF+4`, go to WAIT.
- **WAIT**
  - `imem_req = 0`.
  - On `imem_rvalid` with `kill` set: discard the word, clear `kill`, go to REQ.
  - On `imem_rvalid` with `kill` clear and `!StallD`: deliver the word to IF/ID, go to REQ.
  - On `imem_rvalid` with `kill` clear and `StallD`: capture the word into the buffer, go to FULL.
- **FULL**
  - `imem_req = 0`.
  - When `!StallD`: deliver the buffer to IF/ID, go to REQ.

Redirect (`br_taken`) overrides the FSM transitions above:
- `pcF <= br_target` always. The `+4` from a same-cycle grant is ignored.
- In REQ with a same-cycle grant: go to WAIT with `kill=1`.
- In WAIT: set `kill` if `imem_rvalid` is not also seen this cycle. If `imem_rvalid` arrives in the same cycle, discard the word and go to REQ.
- In FULL: drop the buffer, go to REQ.

IF/ID register, in priority order:
1. `FlushD`: `instrD=NOP`, `validD=0`; `pcD` and `pc4D` unchanged.
2. `StallD`: hold all fields.
3. Delivery this cycle: `instrD`=word, `pcD`=`pc_pend` or `buf_pc`, `pc4D`=`pcD+4`, `validD=1`.
4. Otherwise: `instrD=NOP`, `validD=0` (bubble).

Arithmetic:
- All PC arithmetic is 32-bit modulo 2^32. `32'hFFFF_FFFC + 4` wraps to 0.
- `br_target[1:0]` is passed through unchanged; misalignment is handled elsewhere.

## Timing
- Reset values:
  - `pcF=RESET_PC`, `state=REQ`, `kill=0`.
  - `instrD=NOP`, `pcD=0`, `pc4D=0`, `validD=0`.
  - `imem_req` is high combinationally once `rst_n` rises, given `!StallF`.
- Reset asserted mid-transaction: all state clears immediately. Any response still arriving after release while the FSM is in REQ is ignored; the memory side is reset by the same `rst_n`.
- Latency: grant in cycle N and rvalid in N+1 with no stall gives `validD=1` at the edge ending N+1.
- Peak throughput is one instruction per 2 cycles; this is decided for this revision.
- `imem_rvalid` seen in REQ or FULL is a protocol error and is ignored.
- `imem_req` and `imem_addr` are combinational from state, `pcF` and `StallF`. There is no combinational path from `imem_gnt` or `imem_rvalid` to any request output.
- `StallD` and `FlushD` both high: flush wins.
- `br_taken` together with FULL and `!StallD`: the buffer is dropped and not delivered.

## Test plan
- **Reset and straight-line fetch:** release `rst_n`, gnt=1, rvalid one cycle after grant, `imem_rdata`=`0x00100093`, `0x00200113` → requests to 0x0 then 0x4; `pcD`=0x0 with `instrD`=`0x00100093`, then `pcD`=0x4 with `pc4D`=0x8, `validD=1`.
- **Decode stall while a response arrives:** `StallD=1` for 3 cycles covering rvalid → FSM enters FULL, no new `imem_req`, IF/ID unchanged. The buffered word appears in `instrD` the cycle after `StallD` falls.
- **Redirect with a request outstanding:** grant at 0x8, then `br_taken=1`, `br_target=0x100` before rvalid → the 0x8 response is dropped, the next request goes to 0x100, `validD=0` after flush, and `pcD`=0x100 on the next delivery.
- **Redirect in the grant cycle:** `br_taken` and `imem_gnt` in the same cycle at `pcF=0x10` → `pcF`=0x200 (not 0x14), the 0x10 response is discarded, the next request goes to 0x200.
- **Flush plus stall:** `FlushD=1`, `StallD=1` → `instrD=0x00000013`, `validD=0`.
- **Wrap and async reset:** `RESET_PC=0xFFFFFFFC` → the second request goes to 0x0. Assert `rst_n=0` mid-WAIT → outputs return to their reset values without waiting for a `clk` edge.
